// File: rtl/game_tick_pkg.sv
// rtl/game_tick_pkg.sv - shared register map, state encoding and helpers for game_tick_ctrl
package game_tick_pkg;

  // Register word offsets as seen on HADDR[4:2]
  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_PAC_DIV   = 3'd1;
  localparam logic [2:0] OFF_GHOST_DIV = 3'd2;
  localparam logic [2:0] OFF_FRIGHT    = 3'd3;
  localparam logic [2:0] OFF_PENDING   = 3'd4;
  localparam logic [2:0] OFF_TICKS     = 3'd5;

  // PENDING bit positions
  localparam int PEND_PAC     = 0;
  localparam int PEND_GHOST   = 1;
  localparam int PEND_FRIGHT  = 2;
  localparam int PEND_OVERRUN = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FRIGHT = 2'd2
  } state_t;

  // Ghost divisor doubles while frightened so ghosts move at half speed
  function automatic logic [8:0] ghost_limit(input logic [7:0] div, input logic slow);
    return slow ? {div, 1'b0} : {1'b0, div};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - base-tick divider producing a registered one-cycle step pulse
module tick_divider
  import game_tick_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic [8:0] limit,
  output logic       step
);

  logic [8:0] cnt_q, cnt_d;
  logic       step_q, step_d;

  // limit is the divisor; a zero divisor silences the stream and parks the counter.
  // The >= compare lets the counter recover if the divisor shrinks below it mid-count.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (limit == 9'd0) begin
      cnt_d = '0;
    end else if (en && tick) begin
      if (cnt_q >= limit - 9'd1) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 9'd1;
      end
    end
  end

  // Counter and step pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/game_tick_ctrl.sv
// rtl/game_tick_ctrl.sv - AHB-Lite game tick controller: step dividers, frightened timer, pending irq
module game_tick_ctrl
  import game_tick_pkg::*;
#(
  parameter logic [7:0] PAC_DIV_RST   = 8'd8,
  parameter logic [7:0] GHOST_DIV_RST = 8'd10
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic        tick_in,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        pac_step,
  output logic        ghost_step,
  output logic        frightened,
  output logic        irq
);

  // Bus pipeline
  logic        dp_valid_q, dp_write_q;
  logic [2:0]  dp_addr_q;
  logic        addr_accept;

  // Tick edge detect
  logic        tick_in_q, tick_pulse_q;

  // Programmable state
  logic        en_q, en_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  pac_div_q, pac_div_d;
  logic [7:0]  ghost_div_q, ghost_div_d;
  logic [15:0] fright_q, fright_d;
  logic [3:0]  pending_q, pending_d;
  logic [31:0] ticks_q, ticks_d;
  logic        irq_q;

  // FSM
  state_t      state_q, state_d;
  logic        frightened_q;

  // Internal
  logic        wr_en;
  logic        wr_ctrl, wr_pac, wr_ghost, wr_fright, wr_pending;
  logic        fright_expire;
  logic [3:0]  pend_set, pend_clr;
  logic        pac_step_w, ghost_step_w;
  logic [31:0] rdata;
  logic        unused_bus;

  assign unused_bus  = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0]};
  assign addr_accept = HSEL & HREADY & HTRANS[1];

  assign wr_en      = dp_valid_q & dp_write_q;
  assign wr_ctrl    = wr_en && (dp_addr_q == OFF_CTRL);
  assign wr_pac     = wr_en && (dp_addr_q == OFF_PAC_DIV);
  assign wr_ghost   = wr_en && (dp_addr_q == OFF_GHOST_DIV);
  assign wr_fright  = wr_en && (dp_addr_q == OFF_FRIGHT);
  assign wr_pending = wr_en && (dp_addr_q == OFF_PENDING);

  tick_divider u_pac_div (
    .clk   (HCLK),
    .rst   (HRESET),
    .tick  (tick_pulse_q),
    .en    (en_q),
    .limit ({1'b0, pac_div_q}),
    .step  (pac_step_w)
  );

  tick_divider u_ghost_div (
    .clk   (HCLK),
    .rst   (HRESET),
    .tick  (tick_pulse_q),
    .en    (en_q),
    .limit (ghost_limit(ghost_div_q, frightened_q)),
    .step  (ghost_step_w)
  );

  // Next-state for registers: CPU writes, frightened countdown, tick counter, sticky pending
  always_comb begin
    en_d          = en_q;
    mask_d        = mask_q;
    pac_div_d     = pac_div_q;
    ghost_div_d   = ghost_div_q;
    fright_d      = fright_q;
    fright_expire = 1'b0;

    if (wr_ctrl) begin
      en_d   = HWDATA[0];
      mask_d = HWDATA[7:4];
    end
    if (wr_pac) begin
      pac_div_d = HWDATA[7:0];
    end
    if (wr_ghost) begin
      ghost_div_d = HWDATA[7:0];
    end

    // A CPU load beats the countdown and suppresses the expiry event
    if (wr_fright) begin
      fright_d = HWDATA[15:0];
    end else if (en_q && tick_pulse_q && (fright_q != 16'd0)) begin
      fright_d      = fright_q - 16'd1;
      fright_expire = (fright_q == 16'd1);
    end

    ticks_d = ticks_q + {31'd0, tick_pulse_q};

    pend_set                = '0;
    pend_set[PEND_PAC]      = pac_step_w;
    pend_set[PEND_GHOST]    = ghost_step_w;
    pend_set[PEND_FRIGHT]   = fright_expire;
    pend_set[PEND_OVERRUN]  = (pac_step_w & pending_q[PEND_PAC]) |
                              (ghost_step_w & pending_q[PEND_GHOST]);
    pend_clr  = wr_pending ? HWDATA[3:0] : 4'd0;
    // Set is ORed after the clear so a same-cycle event survives W1C
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // Next FSM state follows the register values being committed this cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_d) state_d = (fright_d != 16'd0) ? FRIGHT : RUN;
      RUN:     if (!en_d) state_d = IDLE;
               else if (fright_d != 16'd0) state_d = FRIGHT;
      FRIGHT:  if (!en_d) state_d = IDLE;
               else if (fright_d == 16'd0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Bus pipeline, tick edge detect and register state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_addr_q    <= '0;
      tick_in_q    <= 1'b0;
      tick_pulse_q <= 1'b0;
      en_q         <= 1'b0;
      mask_q       <= '0;
      pac_div_q    <= PAC_DIV_RST;
      ghost_div_q  <= GHOST_DIV_RST;
      fright_q     <= '0;
      pending_q    <= '0;
      ticks_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      dp_valid_q   <= addr_accept;
      dp_write_q   <= HWRITE;
      dp_addr_q    <= HADDR[4:2];
      tick_in_q    <= tick_in;
      tick_pulse_q <= tick_in & ~tick_in_q;
      en_q         <= en_d;
      mask_q       <= mask_d;
      pac_div_q    <= pac_div_d;
      ghost_div_q  <= ghost_div_d;
      fright_q     <= fright_d;
      pending_q    <= pending_d;
      ticks_q      <= ticks_d;
      irq_q        <= |(pending_q & mask_q);
    end
  end

  // Game mode FSM with registered frightened output
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= IDLE;
      frightened_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frightened_q <= (state_d == FRIGHT);
    end
  end

  // Read data for the data phase of a read; unmapped offsets and idle cycles return 0
  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        OFF_CTRL:      rdata = {24'd0, mask_q, 3'd0, en_q};
        OFF_PAC_DIV:   rdata = {24'd0, pac_div_q};
        OFF_GHOST_DIV: rdata = {24'd0, ghost_div_q};
        OFF_FRIGHT:    rdata = {16'd0, fright_q};
        OFF_PENDING:   rdata = {28'd0, pending_q};
        OFF_TICKS:     rdata = ticks_q;
        default:       rdata = '0;
      endcase
    end
  end

  assign HRDATA     = rdata;
  assign HREADYOUT  = 1'b1;
  assign pac_step   = pac_step_w;
  assign ghost_step = ghost_step_w;
  assign frightened = frightened_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb/tb_game_tick_ctrl.sv - self-checking bench for game_tick_ctrl
module tb_game_tick_ctrl;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic        tick_in;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        pac_step;
  logic        ghost_step;
  logic        frightened;
  logic        irq;

  game_tick_ctrl dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HWDATA     (HWDATA),
    .HSIZE      (HSIZE),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HREADY     (HREADY),
    .HSEL       (HSEL),
    .tick_in    (tick_in),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .pac_step   (pac_step),
    .ghost_step (ghost_step),
    .frightened (frightened),
    .irq        (irq)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_on = 1'b0;
  int pac_seen = 0;
  int ghost_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en;
  logic [3:0]  m_mask;
  logic [7:0]  m_pdiv, m_gdiv;
  int          m_fright;
  logic [3:0]  m_pend;
  logic [31:0] m_ticks;
  int          m_pcnt, m_gcnt;
  logic        m_tick_prev, m_tick_eff;
  logic        m_dp_valid, m_dp_write;
  logic [2:0]  m_dp_addr;
  logic        m_pac_o, m_ghost_o, m_irq_o, m_fr_o;

  task automatic model_step();
    logic [3:0] set;
    logic [3:0] clr;
    logic       wr;
    logic [2:0] a;
    logic       was_fr;
    int         glim;
    if (HRESET) begin
      m_en = 0; m_mask = 0; m_pdiv = 8'd8; m_gdiv = 8'd10; m_fright = 0; m_pend = 0;
      m_ticks = 0; m_pcnt = 0; m_gcnt = 0; m_tick_prev = 0; m_tick_eff = 0;
      m_dp_valid = 0; m_dp_write = 0; m_dp_addr = 0;
      m_pac_o = 0; m_ghost_o = 0; m_irq_o = 0; m_fr_o = 0;
      return;
    end
    was_fr = m_en && (m_fright != 0);
    set = {2'b00, m_ghost_o, m_pac_o};
    if ((m_pend[0] && m_pac_o) || (m_pend[1] && m_ghost_o)) set[3] = 1'b1;
    m_irq_o = ((m_pend & m_mask) != 4'd0);
    m_pac_o = 0;
    m_ghost_o = 0;
    wr = m_dp_valid && m_dp_write;
    a  = m_dp_addr;
    glim = was_fr ? 2 * int'(m_gdiv) : int'(m_gdiv);
    if (m_pdiv == 0) m_pcnt = 0;
    if (glim == 0) m_gcnt = 0;
    if (m_tick_eff) begin
      m_ticks = m_ticks + 32'd1;
      if (m_en) begin
        if (m_pdiv != 0) begin
          m_pcnt++;
          if (m_pcnt >= int'(m_pdiv)) begin m_pcnt = 0; m_pac_o = 1; end
        end
        if (glim != 0) begin
          m_gcnt++;
          if (m_gcnt >= glim) begin m_gcnt = 0; m_ghost_o = 1; end
        end
        if (m_fright != 0 && !(wr && a == 3'd3)) begin
          m_fright--;
          if (m_fright == 0) set[2] = 1'b1;
        end
      end
    end
    clr = 4'd0;
    if (wr) begin
      case (a)
        3'd0: begin m_en = HWDATA[0]; m_mask = HWDATA[7:4]; end
        3'd1: m_pdiv = HWDATA[7:0];
        3'd2: m_gdiv = HWDATA[7:0];
        3'd3: m_fright = int'(HWDATA[15:0]);
        3'd4: clr = HWDATA[3:0];
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | set;
    m_fr_o = m_en && (m_fright != 0);
    m_tick_eff  = tick_in && !m_tick_prev;
    m_tick_prev = tick_in;
    m_dp_valid = HSEL && HREADY && HTRANS[1];
    m_dp_write = HWRITE;
    m_dp_addr  = HADDR[4:2];
  endtask

  function automatic logic [31:0] m_read();
    if (!(m_dp_valid && !m_dp_write)) return 32'd0;
    case (m_dp_addr)
      3'd0: return {24'd0, m_mask, 3'd0, m_en};
      3'd1: return {24'd0, m_pdiv};
      3'd2: return {24'd0, m_gdiv};
      3'd3: return 32'(m_fright);
      3'd4: return {28'd0, m_pend};
      3'd5: return m_ticks;
      default: return 32'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge HCLK or posedge HRESET);
    model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge HCLK);
    if (pac_step === 1'b1) pac_seen++;
    if (ghost_step === 1'b1) ghost_seen++;
    if (cmp_on) begin
      check("cyc_pac_step", {31'd0, pac_step}, {31'd0, m_pac_o});
      check("cyc_ghost_step", {31'd0, ghost_step}, {31'd0, m_ghost_o});
      check("cyc_frightened", {31'd0, frightened}, {31'd0, m_fr_o});
      check("cyc_irq", {31'd0, irq}, {31'd0, m_irq_o});
      check("cyc_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("cyc_hrdata", HRDATA, m_read());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'd0, a};
    cyc();
    bus_idle(); HWDATA = d;
    cyc();
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'd0, a};
    cyc();
    bus_idle();
    @(negedge HCLK);
    d = HRDATA;
    @(posedge HCLK);
    #1;
    check(name, d, exp);
  endtask

  task automatic tick_once(output logic s1p, output logic s2p, output logic s2g, output logic s2f);
    tick_in = 1'b1;
    cyc();
    s1p = pac_step;
    tick_in = 1'b0;
    cyc();
    s2p = pac_step; s2g = ghost_step; s2f = frightened;
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    cyc();
    cyc();
    HRESET = 1'b0;
    cyc();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic a1, a2, a3, a4;
    logic [15:0] s1mask, s2mask, gmask;
    int base;

    HRESET = 1'b1; HADDR = 0; HWDATA = 0; HSIZE = 3'b010; HTRANS = 2'b00;
    HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0; tick_in = 1'b0;
    cyc();
    cyc();
    cmp_on = 1'b1;
    check("rst_pac_step", {31'd0, pac_step}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HRESET = 1'b0;
    cyc();

    // Reset values and unmapped offset
    rd_check("rst_ctrl", 5'h00, 32'd0);
    rd_check("rst_pac_div", 5'h04, 32'd8);
    rd_check("rst_ghost_div", 5'h08, 32'd10);
    rd_check("rst_fright", 5'h0C, 32'd0);
    rd_check("rst_pending", 5'h10, 32'd0);
    rd_check("rst_ticks", 5'h14, 32'd0);
    wr(5'h18, 32'hFFFF_FFFF);
    rd_check("unmapped_read", 5'h18, 32'd0);
    rd_check("ctrl_after_unmapped_wr", 5'h00, 32'd0);

    // PAC_DIV=3, 9 ticks: steps 2 cycles after ticks 3,6,9
    wr(5'h04, 32'd3);
    wr(5'h00, 32'h1);
    base = pac_seen;
    s1mask = 0; s2mask = 0;
    for (int i = 1; i <= 9; i++) begin
      tick_once(a1, a2, a3, a4);
      s1mask[i] = a1;
      s2mask[i] = a2;
    end
    check("pac_latency_not_1", {16'd0, s1mask}, 32'd0);
    check("pac_step_ticks", {16'd0, s2mask}, 32'h0248);
    check("pac_step_count", 32'(pac_seen - base), 32'd3);
    rd_check("ticks_after_9", 5'h14, 32'd9);
    rd_check("pending_overrun", 5'h10, 32'h9);

    // Ghost half speed while frightened, FRIGHT expiry
    do_reset();
    wr(5'h08, 32'd2);
    wr(5'h0C, 32'd5);
    wr(5'h00, 32'h1);
    check("fright_rise", {31'd0, frightened}, 32'd1);
    gmask = 0;
    for (int i = 1; i <= 10; i++) begin
      tick_once(a1, a2, a3, a4);
      gmask[i] = a3;
      check("fright_level", {31'd0, a4}, (i < 5) ? 32'd1 : 32'd0);
    end
    check("ghost_step_ticks", {16'd0, gmask}, 32'h0550);
    rd_check("pending_all", 5'h10, 32'hF);
    rd_check("fright_zero", 5'h0C, 32'd0);

    // irq with mask, W1C, overrun
    do_reset();
    wr(5'h04, 32'd1);
    wr(5'h00, 32'h11);
    tick_once(a1, a2, a3, a4);
    check("irq_set", {31'd0, irq}, 32'd1);
    rd_check("pending_pac", 5'h10, 32'h1);
    wr(5'h10, 32'h1);
    cyc();
    check("irq_clear", {31'd0, irq}, 32'd0);
    tick_once(a1, a2, a3, a4);
    tick_once(a1, a2, a3, a4);
    rd_check("pending_pac_overrun", 5'h10, 32'h9);
    check("irq_again", {31'd0, irq}, 32'd1);

    // W1C of PENDING[0] in the cycle pac_step is high: set wins
    wr(5'h10, 32'hF);
    tick_once(a1, a2, a3, a4);
    rd_check("pending_before_race", 5'h10, 32'h1);
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10;
    cyc();
    check("race_pac_step", {31'd0, pac_step}, 32'd1);
    bus_idle(); HWDATA = 32'h1;
    cyc();
    cyc();
    rd_check("pending_set_wins", 5'h10, 32'h9);

    // PAC_DIV=0 disables pac steps
    wr(5'h04, 32'd0);
    base = pac_seen;
    for (int i = 0; i < 20; i++) tick_once(a1, a2, a3, a4);
    check("pac_div0_none", 32'(pac_seen - base), 32'd0);
    rd_check("ticks_25", 5'h14, 32'd25);

    // Asynchronous reset mid-operation
    wr(5'h04, 32'd1);
    wr(5'h0C, 32'd100);
    tick_once(a1, a2, a3, a4);
    tick_in = 1'b1;
    cyc();
    cyc();
    check("pre_rst_pac", {31'd0, pac_step}, 32'd1);
    check("pre_rst_fright", {31'd0, frightened}, 32'd1);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    HRESET = 1'b1;
    #1;
    check("async_rst_pac", {31'd0, pac_step}, 32'd0);
    check("async_rst_fright", {31'd0, frightened}, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    check("async_rst_hrdata", HRDATA, 32'd0);
    tick_in = 1'b0;
    cyc();
    cyc();
    HRESET = 1'b0;
    cyc();
    rd_check("post_rst_ticks", 5'h14, 32'd0);
    rd_check("post_rst_fright", 5'h0C, 32'd0);
    rd_check("post_rst_pac_div", 5'h04, 32'd8);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
